// File: rtl/mul_wb_arbiter_pkg.sv
// Shared register-file widths for the multiply write-back path.
// REG_SIZE defaults to 32 unless the shared define has already set it.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

package mul_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/mul_wb_fifo.sv
// Buffer for completed multiply results awaiting the register-file write port.
// Holds storage, pointers, occupancy count and a per-entry hazard match vector.
module mul_wb_fifo
  import mul_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_result,
  input  logic                  push_zero,
  input  logic                  push_ovf,
  input  logic [REG_ADDR_W-1:0] push_dst,
  input  logic                  pop,
  input  logic [REG_ADDR_W-1:0] hz_src,
  output logic [WIDTH-1:0]      head_result,
  output logic                  head_zero,
  output logic                  head_ovf,
  output logic [REG_ADDR_W-1:0] head_dst,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH-1:0]      match
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]      result_q [DEPTH];
  logic                  zero_q   [DEPTH];
  logic                  ovf_q    [DEPTH];
  logic [REG_ADDR_W-1:0] dst_q    [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(DEPTH));
  assign head_result = result_q[rd_ptr_q];
  assign head_zero   = zero_q[rd_ptr_q];
  assign head_ovf    = ovf_q[rd_ptr_q];
  assign head_dst    = dst_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Push and pop never target the same slot: that needs empty+pop or full+push.
  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (dst_q[i] == hz_src);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset; valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      result_q[wr_ptr_q] <= push_result;
      zero_q[wr_ptr_q]   <= push_zero;
      ovf_q[wr_ptr_q]    <= push_ovf;
      dst_q[wr_ptr_q]    <= push_dst;
    end
  end

endmodule

// File: rtl/mul_wb_arbiter.sv
// Shares the register-file write port between the ALU and buffered multiply results.
// ALU always wins; multiplies drain in order from a small FIFO when the port is idle.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module mul_wb_arbiter
  import mul_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned REG_SIZE = `REG_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m5_valid,
  input  logic [REG_SIZE-1:0]   m5_result,
  input  logic                  m5_zero,
  input  logic                  m5_overflow,
  input  logic [REG_ADDR_W-1:0] m5_dst,
  input  logic                  alu_wb_valid,
  input  logic [REG_SIZE-1:0]   alu_wb_data,
  input  logic [REG_ADDR_W-1:0] alu_wb_dst,
  input  logic [REG_ADDR_W-1:0] hz_src,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_SIZE-1:0]   rf_wdata,
  output logic                  mul_ovf,
  output logic [REG_ADDR_W-1:0] mul_ovf_dst,
  output logic                  mul_stall,
  output logic                  hz_hit
);

  logic                  push, pop, empty, full;
  logic [REG_SIZE-1:0]   head_result;
  logic                  head_zero, head_ovf;
  logic [REG_ADDR_W-1:0] head_dst;
  logic [DEPTH-1:0]      match;

  // Zero flag is kept per entry for future branch forwarding.
  logic unused_head_zero;
  assign unused_head_zero = head_zero;

  mul_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REG_SIZE)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_result (m5_result),
    .push_zero   (m5_zero),
    .push_ovf    (m5_overflow),
    .push_dst    (m5_dst),
    .pop         (pop),
    .hz_src      (hz_src),
    .head_result (head_result),
    .head_zero   (head_zero),
    .head_ovf    (head_ovf),
    .head_dst    (head_dst),
    .empty       (empty),
    .full        (full),
    .match       (match)
  );

  // Stall depends only on registered occupancy, never on this cycle's ALU request.
  assign mul_stall = full;
  assign push      = m5_valid & ~full;
  assign pop       = ~alu_wb_valid & ~empty;
  assign hz_hit    = (hz_src != '0) && (|match);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (alu_wb_valid) begin
      rf_we    = 1'b1;
      rf_waddr = alu_wb_dst;
      rf_wdata = alu_wb_data;
    end else if (!empty) begin
      rf_we    = (head_dst != '0);
      rf_waddr = head_dst;
      rf_wdata = head_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ovf     <= 1'b0;
      mul_ovf_dst <= '0;
    end else begin
      mul_ovf <= pop & head_ovf;
      if (pop && head_ovf) mul_ovf_dst <= head_dst;
    end
  end

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// Directed bench for mul_wb_arbiter: single write, ALU priority, full drain,
// dst-0/overflow, hazard lookup and mid-drain reset.
module tb_mul_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m5_valid, m5_zero, m5_overflow;
  logic [31:0] m5_result;
  logic [4:0]  m5_dst;
  logic        alu_wb_valid;
  logic [31:0] alu_wb_data;
  logic [4:0]  alu_wb_dst;
  logic [4:0]  hz_src;
  logic        rf_we, mul_ovf, mul_stall, hz_hit;
  logic [4:0]  rf_waddr, mul_ovf_dst;
  logic [31:0] rf_wdata;

  int n_vec = 0;
  int n_bad = 0;
  int q[$];

  always #5 clk = ~clk;

  mul_wb_arbiter #(
    .DEPTH    (4),
    .REG_SIZE (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m5_valid     (m5_valid),
    .m5_result    (m5_result),
    .m5_zero      (m5_zero),
    .m5_overflow  (m5_overflow),
    .m5_dst       (m5_dst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_dst   (alu_wb_dst),
    .hz_src       (hz_src),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .mul_ovf      (mul_ovf),
    .mul_ovf_dst  (mul_ovf_dst),
    .mul_stall    (mul_stall),
    .hz_hit       (hz_hit)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU busy for alu_cyc cycles while multiplies first..last are offered back to back;
  // the bench keeps its own queue of buffered dsts to predict stall and write order.
  task automatic run_mix(input int alu_cyc, input int first, input int last, input int max_cyc);
    int nxt;
    logic exp_stall;
    nxt = first;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      alu_wb_valid = (c < alu_cyc);
      alu_wb_dst   = 5'd20;
      alu_wb_data  = 32'hA1A1_0000 + 32'(c);
      m5_valid     = (nxt <= last);
      m5_dst       = 5'(nxt);
      m5_result    = 32'h200 + 32'(nxt);
      m5_overflow  = 1'b0;
      @(negedge clk);
      exp_stall = (q.size() == 4);
      check_eq("mix_stall", 32'(mul_stall), 32'(exp_stall));
      if (alu_wb_valid) begin
        check_eq("mix_alu_we", 32'(rf_we), 32'd1);
        check_eq("mix_alu_addr", 32'(rf_waddr), 32'd20);
        check_eq("mix_alu_data", rf_wdata, 32'hA1A1_0000 + 32'(c));
      end else if (q.size() > 0) begin
        check_eq("mix_mul_we", 32'(rf_we), 32'd1);
        check_eq("mix_mul_addr", 32'(rf_waddr), 32'(q[0]));
        check_eq("mix_mul_data", rf_wdata, 32'h200 + 32'(q[0]));
        void'(q.pop_front());
      end else begin
        check_eq("mix_idle_we", 32'(rf_we), 32'd0);
      end
      if (m5_valid && !exp_stall) begin
        q.push_back(nxt);
        nxt++;
      end
    end
    check_eq("mix_drained", 32'(q.size()), 32'd0);
    check_eq("mix_all_offered", 32'(nxt), 32'(last + 1));
  endtask

  initial begin
    rst_n        = 1'b0;
    m5_valid     = 1'b0;
    m5_zero      = 1'b0;
    m5_overflow  = 1'b0;
    m5_result    = '0;
    m5_dst       = '0;
    alu_wb_valid = 1'b0;
    alu_wb_data  = '0;
    alu_wb_dst   = '0;
    hz_src       = '0;

    // Reset state
    @(negedge clk);
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_stall", 32'(mul_stall), 32'd0);
    check_eq("rst_hz", 32'(hz_hit), 32'd0);
    check_eq("rst_ovf", 32'(mul_ovf), 32'd0);
    check_eq("rst_ovf_dst", 32'(mul_ovf_dst), 32'd0);
    step();
    rst_n = 1'b1;

    // Single multiply, one-cycle latency, no bypass
    step();
    m5_valid = 1'b1; m5_dst = 5'd5; m5_result = 32'h0000_002A;
    @(negedge clk);
    check_eq("single_nobypass", 32'(rf_we), 32'd0);
    step();
    m5_valid = 1'b0;
    @(negedge clk);
    check_eq("single_we", 32'(rf_we), 32'd1);
    check_eq("single_addr", 32'(rf_waddr), 32'd5);
    check_eq("single_data", rf_wdata, 32'h2A);
    step();
    @(negedge clk);
    check_eq("single_after", 32'(rf_we), 32'd0);

    // ALU priority: 6 ALU cycles, muls 1..4; then full FIFO drain with m5 held
    run_mix(6, 1, 4, 12);
    run_mix(4, 11, 18, 14);

    // Overflow pulses, including a dst-0 entry that must not write
    step();
    m5_valid = 1'b1; m5_dst = 5'd9; m5_result = 32'h77; m5_overflow = 1'b1;
    @(negedge clk);
    check_eq("ovf_idle", 32'(mul_ovf), 32'd0);
    step();
    m5_dst = 5'd0; m5_result = 32'h55;
    @(negedge clk);
    check_eq("ovf9_we", 32'(rf_we), 32'd1);
    check_eq("ovf9_addr", 32'(rf_waddr), 32'd9);
    check_eq("ovf9_data", rf_wdata, 32'h77);
    check_eq("ovf_notyet", 32'(mul_ovf), 32'd0);
    step();
    m5_valid = 1'b0; m5_overflow = 1'b0;
    @(negedge clk);
    check_eq("ovf9_pulse", 32'(mul_ovf), 32'd1);
    check_eq("ovf9_dst", 32'(mul_ovf_dst), 32'd9);
    check_eq("dst0_we", 32'(rf_we), 32'd0);
    step();
    @(negedge clk);
    check_eq("ovf0_pulse", 32'(mul_ovf), 32'd1);
    check_eq("ovf0_dst", 32'(mul_ovf_dst), 32'd0);
    check_eq("ovf0_we", 32'(rf_we), 32'd0);
    step();
    @(negedge clk);
    check_eq("ovf_end", 32'(mul_ovf), 32'd0);

    // Hazard lookup
    step();
    alu_wb_valid = 1'b1; alu_wb_dst = 5'd20;
    m5_valid = 1'b1; m5_dst = 5'd7; m5_result = 32'h7; hz_src = 5'd7;
    @(negedge clk);
    check_eq("hz_before_push", 32'(hz_hit), 32'd0);
    step();
    m5_valid = 1'b0;
    @(negedge clk);
    check_eq("hz_hit7", 32'(hz_hit), 32'd1);
    hz_src = 5'd0;
    #1 check_eq("hz_src0", 32'(hz_hit), 32'd0);
    hz_src = 5'd3;
    #1 check_eq("hz_src3", 32'(hz_hit), 32'd0);
    step();
    alu_wb_valid = 1'b0; hz_src = 5'd7;
    @(negedge clk);
    check_eq("hz_pop_we", 32'(rf_we), 32'd1);
    check_eq("hz_pop_addr", 32'(rf_waddr), 32'd7);
    check_eq("hz_popping", 32'(hz_hit), 32'd1);
    step();
    @(negedge clk);
    check_eq("hz_after_pop", 32'(hz_hit), 32'd0);

    // Reset with 3 buffered entries
    alu_wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      m5_valid = 1'b1; m5_dst = 5'(21 + i); m5_result = 32'h300 + 32'(i);
    end
    step();
    m5_valid = 1'b0; hz_src = 5'd21;
    @(negedge clk);
    check_eq("rst3_hz", 32'(hz_hit), 32'd1);
    check_eq("rst3_alu_addr", 32'(rf_waddr), 32'd20);
    #2;
    rst_n = 1'b0; alu_wb_valid = 1'b0;
    #1;
    check_eq("rst3_we", 32'(rf_we), 32'd0);
    check_eq("rst3_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst3_hz_clr", 32'(hz_hit), 32'd0);
    check_eq("rst3_stall", 32'(mul_stall), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst3_nowrite", 32'(rf_we), 32'd0);
      check_eq("rst3_hz_after", 32'(hz_hit), 32'd0);
    end

    // Pointers restart cleanly after reset
    step();
    m5_valid = 1'b1; m5_dst = 5'd12; m5_result = 32'hC0FFEE;
    step();
    m5_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_we", 32'(rf_we), 32'd1);
    check_eq("post_rst_addr", 32'(rf_waddr), 32'd12);
    check_eq("post_rst_data", rf_wdata, 32'hC0FFEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_wb_arbiter.md
MUL_WB_ARBITER -- requirements
Module: mul_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered multiply results (power of two, 2..8).
REQ-002 Parameter REG_SIZE, default `REG_SIZE (32), datapath width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 m5_valid  in  1  multiply pipeline last stage holds a completed result this cycle.
REQ-006 m5_result  in  REG_SIZE  multiply result.
REQ-007 m5_zero  in  1  result-is-zero flag.
REQ-008 m5_overflow  in  1  multiply overflow flag.
REQ-009 m5_dst  in  5  destination register.
REQ-010 alu_wb_valid  in  1  ALU result requests the register-file write port.
REQ-011 alu_wb_data  in  REG_SIZE  ALU write data.
REQ-012 alu_wb_dst  in  5  ALU destination register.
REQ-013 hz_src  in  5  source register queried by hazard unit.
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_waddr  out  5  register-file write address.
REQ-016 rf_wdata  out  REG_SIZE  register-file write data.
REQ-017 mul_ovf  out  1  one-cycle pulse: buffered multiply with overflow retired.
REQ-018 mul_ovf_dst  out  5  dst of that overflowing multiply.
REQ-019 mul_stall  out  1  multiply pipeline must freeze; m5 inputs held.
REQ-020 hz_hit  out  1  hz_src (nonzero) matches dst of a buffered, unretired multiply.

Function
REQ-021 m5 accepted into FIFO in any cycle with m5_valid=1 and mul_stall=0.
REQ-022 mul_stall SHALL be registered-state-derived: 1 when count==DEPTH, else 0; no combinational path from alu_wb_valid.
REQ-023 Write port arbitration: alu_wb_valid=1 wins; rf_we=1, rf_waddr=alu_wb_dst, rf_wdata=alu_wb_data, same cycle (combinational).
REQ-024 Otherwise if FIFO non-empty: head popped, rf_we=1 with head dst/result, same cycle.
REQ-025 Entries with dst==0 SHALL still pop in order but drive rf_we=0.
REQ-026 FIFO empty and no ALU request: rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-027 Minimum latency m5 accept -> rf write: 1 cycle (entry visible at head the cycle after push); no bypass of empty FIFO.
REQ-028 Simultaneous push and pop: both occur; count unchanged; full FIFO with pop still holds mul_stall=1 that cycle (no push).
REQ-029 Pointers wrap modulo DEPTH; count range 0..DEPTH, width clog2(DEPTH)+1.
REQ-030 mul_ovf/mul_ovf_dst registered: asserted the cycle after an entry with overflow=1 pops, regardless of dst==0.
REQ-031 hz_hit combinational over valid entries only; hz_src==0 gives 0; entry popping this cycle still counts.
REQ-032 Zero flag stored per entry but not output; reserved for branch forwarding.

Reset
REQ-033 rst_n low asynchronously clears pointers, count, valid bits, mul_ovf=0, mul_ovf_dst=0.
REQ-034 During and after reset: rf_we=0 (unless alu_wb_valid), mul_stall=0, hz_hit=0; buffered entries discarded, not written.
REQ-035 Reset mid-drain SHALL not produce a partial or spurious write on the following edge.

Structure
REQ-036 REG_SIZE and register-address width come from the shared define.v; no new package types.
REQ-037 One sub-module: mul_wb_fifo (storage, pointers, count, match vector); arbitration and flag logic in top.

Verification
REQ-038 Single mul: m5_valid one cycle, dst=5, result=0x0000_002A -> next cycle rf_we=1, waddr=5, wdata=0x2A.
REQ-039 ALU priority: ALU valid 6 cycles while 4 muls (dst 1..4) arrive -> mul_stall=1 after 4th push, muls written in order 1,2,3,4 starting cycle ALU drops.
REQ-040 Full+pop: FIFO full, ALU idle, m5_valid held -> one pop per cycle, stall clears the cycle count<DEPTH, no entry lost or duplicated.
REQ-041 dst 0 and overflow: entry dst=0, overflow=1 -> rf_we=0 on pop, mul_ovf=1 with mul_ovf_dst=0 next cycle.
REQ-042 Hazard: buffered dst=7, hz_src=7 -> hz_hit=1; hz_src=0 -> hz_hit=0; after pop hz_hit=0.
REQ-043 Reset with 3 entries: rst_n low mid-cycle -> outputs cleared immediately, no writes after rst_n high.
